fir_cfg_sequencer: RTL and testbench
====================================

FIR_CFG_SEQUENCER -- requirements
Module: fir_cfg_sequencer

Interface
REQ-001 Parameter DWIDTH, default 8, coefficient and sample width.
REQ-002 Parameter AWIDTH, default 4, coefficient address width.
REQ-003 Parameter WINLEN, default 12, number of coefficients per load; SHALL satisfy WINLEN <= 2^AWIDTH.
REQ-004 Parameter CWIDTH, default 6, width of the in-flight sample counter.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 load_req  in  1  level request to reload coefficients.
REQ-008 coef_valid  in  1  host coefficient valid.
REQ-009 coef_busy  out  1  coefficient back-pressure; a transfer occurs when coef_valid=1 and coef_busy=0.
REQ-010 coef_data  in  DWIDTH  coefficient value, in ascending address order.
REQ-011 up_din_valid / up_din_busy / up_din_data  in / out / in  1 / 1 / DWIDTH  upstream sample channel.
REQ-012 fir_din_valid / fir_din_busy / fir_din_data  out / in / out  1 / 1 / DWIDTH  sample channel to the FIR.
REQ-013 fir_dout_valid, fir_dout_busy  in, in  1, 1  monitor taps on the FIR output handshake.
REQ-014 cfg_valid / cfg_busy / cfg_addr / cfg_data  out / in / out / out  1 / 1 / AWIDTH / DWIDTH  FIR coefficient write port.
REQ-015 load_done  out  1  one-cycle pulse when a load completes.
REQ-016 coef_loaded  out  1  high once at least one complete load has finished since reset.

Function
REQ-017 All channels SHALL use valid/busy handshakes; a transfer occurs on a cycle where valid=1 and busy=0; a producer SHALL hold valid and data stable until the transfer.
REQ-018 The FSM SHALL have states IDLE, DRAIN, LOAD and DONE.
REQ-019 IDLE, sample gate: fir_din_valid = up_din_valid & coef_loaded & ~full, up_din_busy = fir_din_busy | ~coef_loaded | full, and fir_din_data = up_din_data (combinational).
REQ-020 In DRAIN, LOAD and DONE, fir_din_valid SHALL be 0 and up_din_busy SHALL be 1.
REQ-021 In-flight counter: increments on each FIR input transfer and decrements on each FIR output transfer (fir_dout_valid & ~fir_dout_busy).
REQ-022 If both counter events occur in the same cycle, the counter SHALL hold its value.
REQ-023 full SHALL be asserted when the counter equals 2^CWIDTH-1.
REQ-024 A decrement at 0 SHALL be ignored.
REQ-025 IDLE -> DRAIN when load_req=1; a sample transfer in that same cycle SHALL still be accepted and counted.
REQ-026 DRAIN -> LOAD on the first cycle the counter is 0; the address counter SHALL be cleared to 0 on entry to LOAD.
REQ-027 coef_busy SHALL be 1 except in LOAD when fewer than WINLEN coefficients have been accepted and (cfg_valid=0 or cfg_busy=0).
REQ-028 cfg_valid, cfg_addr and cfg_data SHALL be registered; a coefficient transfer loads cfg_data with coef_data, loads cfg_addr with the accepted-coefficient index, and sets cfg_valid.
REQ-029 A cfg transfer with no new coefficient transfer in the same cycle SHALL clear cfg_valid.
REQ-030 LOAD -> DONE on the cfg transfer with cfg_addr = WINLEN-1.
REQ-031 DONE SHALL last one cycle, assert load_done=1, set coef_loaded=1, and return to IDLE.
REQ-032 load_req held high SHALL start a new load immediately after DONE.
REQ-033 load_req changes during DRAIN, LOAD or DONE SHALL be ignored.
REQ-034 Minimum LOAD-to-DONE latency SHALL be WINLEN+1 cycles with continuous coef_valid and cfg_busy=0.

Reset
REQ-035 With rst_n=0 at a rising edge: state=IDLE, in-flight counter=0, address counter=0, cfg_valid=0, cfg_addr=0, cfg_data=0, load_done=0, coef_loaded=0.
REQ-036 With rst_n=0 at a rising edge, the combinational outputs SHALL follow from the reset state: fir_din_valid=0, up_din_busy=1, coef_busy=1.
REQ-037 A reset during DRAIN or LOAD SHALL abort the load with no cfg write after the reset edge; coef_loaded SHALL be 0, blocking samples until a full reload.

Verification
REQ-038 Samples before any load: up_din_valid=1 for 10 cycles -> fir_din_valid=0, up_din_busy=1 throughout.
REQ-039 First load, WINLEN=12, coefs 1..12 continuous, cfg_busy=0 -> cfg writes addr 0..11 with data 1..12 on consecutive cycles, load_done one cycle after addr 11, coef_loaded=1.
REQ-040 Drain: 3 samples accepted with FIR outputs stalled, then load_req -> stays in DRAIN, coef_busy=1; release 3 outputs -> LOAD entered the cycle after the counter reaches 0.
REQ-041 Back-pressure: cfg_busy=1 for 4 cycles at addr 5 -> cfg_addr/cfg_data held at 5/6, coef_busy=1, no coefficient lost; load_done 4 cycles later than in REQ-039.
REQ-042 Simultaneous in/out transfers for 20 cycles at a counter value of 2 -> counter stays 2; counter at 63 (CWIDTH=6) -> up_din_busy=1.
REQ-043 Reset after 7 coefficients accepted -> cfg_valid=0, coef_loaded=0, state IDLE; the next load restarts at addr 0.

Source files
------------

// File: rtl/fir_cfg_sequencer.sv
// rtl/fir_cfg_sequencer.sv - gates FIR sample flow, drains in-flight samples, then streams a coefficient window into the FIR
module fir_cfg_sequencer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int WINLEN = 12,
  parameter int CWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              coef_valid,
  output logic              coef_busy,
  input  logic [DWIDTH-1:0] coef_data,
  input  logic              up_din_valid,
  output logic              up_din_busy,
  input  logic [DWIDTH-1:0] up_din_data,
  output logic              fir_din_valid,
  input  logic              fir_din_busy,
  output logic [DWIDTH-1:0] fir_din_data,
  input  logic              fir_dout_valid,
  input  logic              fir_dout_busy,
  output logic              cfg_valid,
  input  logic              cfg_busy,
  output logic [AWIDTH-1:0] cfg_addr,
  output logic [DWIDTH-1:0] cfg_data,
  output logic              load_done,
  output logic              coef_loaded
);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DONE} state_t;

  localparam logic [CWIDTH-1:0] CNT_MAX   = '1;
  localparam logic [AWIDTH:0]   WIN       = (AWIDTH+1)'(WINLEN);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WINLEN - 1);

  state_t              state_q, state_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  // acc counts accepted coefficients; one extra bit so it can reach WINLEN == 2^AWIDTH
  logic [AWIDTH:0]     acc_q, acc_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic [AWIDTH-1:0]   cfg_addr_q, cfg_addr_d;
  logic [DWIDTH-1:0]   cfg_data_q, cfg_data_d;
  logic                load_done_q, load_done_d;
  logic                coef_loaded_q, coef_loaded_d;

  logic in_idle, full, in_xfer, out_xfer, cfg_xfer, coef_xfer;

  assign in_idle       = (state_q == IDLE);
  assign full          = (cnt_q == CNT_MAX);
  assign fir_din_valid = in_idle & up_din_valid & coef_loaded_q & ~full;
  assign up_din_busy   = ~in_idle | fir_din_busy | ~coef_loaded_q | full;
  assign fir_din_data  = up_din_data;

  assign in_xfer   = fir_din_valid & ~fir_din_busy;
  assign out_xfer  = fir_dout_valid & ~fir_dout_busy;
  assign cfg_xfer  = cfg_valid_q & ~cfg_busy;
  assign coef_busy = ~((state_q == LOAD) & (acc_q < WIN) & (~cfg_valid_q | ~cfg_busy));
  assign coef_xfer = coef_valid & ~coef_busy;

  assign cfg_valid   = cfg_valid_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_data    = cfg_data_q;
  assign load_done   = load_done_q;
  assign coef_loaded = coef_loaded_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_addr_d    = cfg_addr_q;
    cfg_data_d    = cfg_data_q;
    load_done_d   = 1'b0;
    coef_loaded_d = coef_loaded_q;

    if (in_xfer && !out_xfer) begin
      cnt_d = cnt_q + CWIDTH'(1);
    end else if (out_xfer && !in_xfer && cnt_q != '0) begin
      cnt_d = cnt_q - CWIDTH'(1);
    end

    // A new coefficient refills the one-deep cfg register even while it drains
    if (coef_xfer) begin
      cfg_valid_d = 1'b1;
      cfg_addr_d  = acc_q[AWIDTH-1:0];
      cfg_data_d  = coef_data;
      acc_d       = acc_q + (AWIDTH+1)'(1);
    end else if (cfg_xfer) begin
      cfg_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (load_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = LOAD;
          acc_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_xfer && cfg_addr_q == LAST_ADDR) begin
          state_d       = DONE;
          load_done_d   = 1'b1;
          coef_loaded_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_data_q    <= '0;
      load_done_q   <= 1'b0;
      coef_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_data_q    <= cfg_data_d;
      load_done_q   <= load_done_d;
      coef_loaded_q <= coef_loaded_d;
    end
  end

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb/tb_fir_cfg_sequencer.sv - scoreboard bench for fir_cfg_sequencer
module tb_fir_cfg_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int WL = 12;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n, load_req, coef_valid, coef_busy;
  logic [DW-1:0] coef_data;
  logic          up_din_valid, up_din_busy;
  logic [DW-1:0] up_din_data;
  logic          fir_din_valid, fir_din_busy;
  logic [DW-1:0] fir_din_data;
  logic          fir_dout_valid, fir_dout_busy;
  logic          cfg_valid, cfg_busy;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          load_done, coef_loaded;

  always #5 clk = ~clk;

  fir_cfg_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .WINLEN(WL), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req),
    .coef_valid(coef_valid), .coef_busy(coef_busy), .coef_data(coef_data),
    .up_din_valid(up_din_valid), .up_din_busy(up_din_busy), .up_din_data(up_din_data),
    .fir_din_valid(fir_din_valid), .fir_din_busy(fir_din_busy), .fir_din_data(fir_din_data),
    .fir_dout_valid(fir_dout_valid), .fir_dout_busy(fir_dout_busy),
    .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .load_done(load_done), .coef_loaded(coef_loaded)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stall_left = 0;
  int lat, got, n;
  bit ok;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_valid && !cfg_busy) begin
      if (exp_q.size() == 0) begin
        check_eq("cfg_unexp", 32'(cfg_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("cfg_addr", 32'(cfg_addr), 32'(mon_e[AW+DW-1:DW]));
        check_eq("cfg_data", 32'(cfg_data), 32'(mon_e[DW-1:0]));
      end
    end
    if (fir_din_valid && !fir_din_busy)
      check_eq("fir_data", 32'(fir_din_data), 32'(up_din_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_left > 0) stall_left--;
    else cfg_busy = 1'b0;
  endtask

  task automatic load_coefs(input int base, input int num, input int stall_at, output int lat_o);
    int t0;
    int w;
    bit hold_ok;
    hold_ok = 1'b1;
    t0 = 0;
    lat_o = -1;
    for (int i = 0; i < num; i++) begin
      coef_valid = 1'b1;
      coef_data  = DW'(base + i + 1);
      w = 0;
      @(negedge clk);
      while (coef_busy && w < 300) begin
        if (cfg_busy && (cfg_addr !== AW'(stall_at) || cfg_data !== DW'(base + stall_at + 1) || !cfg_valid))
          hold_ok = 1'b0;
        w++;
        tick();
        @(negedge clk);
      end
      if (coef_busy) begin
        check_eq("coef_tmo", 32'(coef_busy), 32'd0);
        coef_valid = 1'b0;
        return;
      end
      exp_q.push_back({AW'(i), DW'(base + i + 1)});
      if (i == 0) t0 = cyc;
      tick();
      if (i == stall_at) begin
        cfg_busy   = 1'b1;
        stall_left = 3;
      end
    end
    coef_valid = 1'b0;
    if (num < WL) return;
    w = 0;
    @(negedge clk);
    while (!load_done && w < 300) begin
      w++;
      @(negedge clk);
    end
    check_eq("load_done", 32'(load_done), 32'd1);
    lat_o = cyc - t0;
    if (stall_at >= 0 && stall_at < WL) check_eq("stall_hold", 32'(hold_ok), 32'd1);
  endtask

  task automatic send_samples(input int num);
    int w;
    up_din_valid = 1'b1;
    for (int i = 0; i < num; i++) begin
      up_din_data = DW'($urandom);
      w = 0;
      @(negedge clk);
      while (up_din_busy && w < 100) begin
        w++;
        tick();
        @(negedge clk);
      end
      if (up_din_busy) begin
        check_eq("samp_tmo", 32'(up_din_busy), 32'd0);
        break;
      end
      tick();
    end
    up_din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load_req = 1'b1; coef_valid = 1'b1; coef_data = '0;
    up_din_valid = 1'b1; up_din_data = 8'h5a; fir_din_busy = 1'b0;
    fir_dout_valid = 1'b0; fir_dout_busy = 1'b0; cfg_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check_eq("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check_eq("rst_cfg_data", 32'(cfg_data), 32'd0);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_coef_loaded", 32'(coef_loaded), 32'd0);
    check_eq("rst_fir_valid", 32'(fir_din_valid), 32'd0);
    check_eq("rst_up_busy", 32'(up_din_busy), 32'd1);
    check_eq("rst_coef_busy", 32'(coef_busy), 32'd1);
    tick();
    rst_n = 1'b1; load_req = 1'b0; coef_valid = 1'b0;

    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fir_din_valid || !up_din_busy) ok = 1'b0;
      tick();
    end
    check_eq("pre_load_gate", 32'(ok), 32'd1);
    up_din_valid = 1'b0;

    load_req = 1'b1; tick(); load_req = 1'b0;
    load_coefs(0, WL, -1, lat);
    check_eq("lat_first", 32'(lat), 32'(WL + 1));
    check_eq("loaded_first", 32'(coef_loaded), 32'd1);
    @(negedge clk);
    check_eq("done_pulse", 32'(load_done), 32'd0);
    tick();

    send_samples(3);
    load_req = 1'b1; tick(); load_req = 1'b0;
    ok = 1'b1;
    up_din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!coef_busy || !up_din_busy || fir_din_valid) ok = 1'b0;
      load_req = (i == 1);
      tick();
    end
    up_din_valid = 1'b0; load_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fir_dout_valid = 1'b1; tick(); fir_dout_valid = 1'b0;
      if (k < 2) begin
        @(negedge clk);
        if (!coef_busy) ok = 1'b0;
        tick();
      end
    end
    check_eq("drain_hold", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("drain_last", 32'(coef_busy), 32'd1);
    tick();
    @(negedge clk);
    check_eq("load_entry", 32'(coef_busy), 32'd0);
    tick();
    load_coefs(20, WL, -1, lat);
    check_eq("lat_drain", 32'(lat), 32'(WL + 1));
    tick();

    load_req = 1'b1; tick();
    load_coefs(40, WL, 5, lat);
    check_eq("lat_stall", 32'(lat), 32'(WL + 5));
    tick(); tick();
    load_req = 1'b0;
    @(negedge clk);
    check_eq("hold_drain", 32'(coef_busy), 32'd1);
    tick();
    @(negedge clk);
    check_eq("hold_restart", 32'(coef_busy), 32'd0);
    tick();
    load_coefs(60, WL, -1, lat);
    check_eq("lat_hold", 32'(lat), 32'(WL + 1));
    tick();

    fir_dout_valid = 1'b1; repeat (3) tick(); fir_dout_valid = 1'b0;
    send_samples(2);
    up_din_valid = 1'b1; fir_dout_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!fir_din_valid || up_din_busy) ok = 1'b0;
      tick();
    end
    fir_dout_valid = 1'b0;
    check_eq("simul_flow", 32'(ok), 32'd1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!up_din_busy) got++;
      tick();
    end
    check_eq("fill_count", 32'(got), 32'((1 << CW) - 1 - 2));
    @(negedge clk);
    check_eq("full_busy", 32'(up_din_busy), 32'd1);
    check_eq("full_valid", 32'(fir_din_valid), 32'd0);
    tick();
    fir_dout_valid = 1'b1; tick(); fir_dout_valid = 1'b0;
    @(negedge clk);
    check_eq("unfull", 32'(up_din_busy), 32'd0);
    tick();
    up_din_valid = 1'b0;

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_q.delete();
    up_din_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_loaded", 32'(coef_loaded), 32'd0);
    check_eq("rst_gate", 32'(up_din_busy), 32'd1);
    tick();
    up_din_valid = 1'b0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    load_coefs(80, 7, -1, lat);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_valid", 32'(cfg_valid), 32'd0);
    check_eq("abort_loaded", 32'(coef_loaded), 32'd0);
    check_eq("abort_busy", 32'(coef_busy), 32'd1);
    tick();
    load_req = 1'b1; tick(); load_req = 1'b0;
    load_coefs(100, WL, -1, lat);
    check_eq("lat_reload", 32'(lat), 32'(WL + 1));
    check_eq("loaded_reload", 32'(coef_loaded), 32'd1);
    tick();
    check_eq("cfg_q_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
